// File: rtl/fpu_link_pkg.sv
// Shared state encoding and sizing helpers for the FPU byte-serial link.
package fpu_link_pkg;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StIssue  = 2'd1,
        StWait   = 2'd2,
        StUnload = 2'd3
    } link_state_e;

    // Bytes in one operand frame.
    function automatic int unsigned op_bytes(int unsigned num_ops, int unsigned op_width);
        return (num_ops * op_width) / 8;
    endfunction

    // Bytes in one result.
    function automatic int unsigned res_bytes(int unsigned res_width);
        return res_width / 8;
    endfunction

    // Width of a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpu_link_ser.sv
// Captures one FP result and streams it out LSB byte first.
module fpu_link_ser
    import fpu_link_pkg::*;
#(
    parameter int unsigned RES_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 capture,
    input  logic [RES_WIDTH-1:0] res_data,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    output logic                 done
);
    localparam int unsigned RES_BYTES = res_bytes(RES_WIDTH);
    localparam int unsigned CW        = cnt_width(RES_BYTES);

    logic [RES_WIDTH-1:0] shreg;
    logic [CW-1:0]        cnt;
    logic                 last;

    // The current byte always sits in the low lane of the shift register.
    assign out_byte = shreg[7:0];
    assign last     = (cnt == CW'(RES_BYTES - 1));
    assign done     = out_valid & out_ready & last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (abort) begin
            shreg     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            shreg     <= res_data;
            cnt       <= '0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            shreg <= shreg >> 8;
            if (last) begin
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_byte_link.sv
// Byte-serial front end for an FP core: gathers operands, issues them, serialises the result.
module fpu_byte_link
    import fpu_link_pkg::*;
#(
    parameter int unsigned NUM_OPS   = 4,
    parameter int unsigned OP_WIDTH  = 32,
    parameter int unsigned RES_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        abort,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_OPS*OP_WIDTH-1:0] op_data,
    output logic                        op_valid,
    input  logic                        op_ready,
    input  logic [RES_WIDTH-1:0]        res_data,
    input  logic                        res_valid,
    output logic                        res_ready,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        timeout_err,
    output logic [15:0]                 frames_done
);
    localparam int unsigned OP_BYTES = op_bytes(NUM_OPS, OP_WIDTH);
    localparam int unsigned IN_CW    = cnt_width(OP_BYTES);
    localparam int unsigned WAIT_CW  = cnt_width(TIMEOUT);

    if (OP_WIDTH % 8 != 0) begin : g_bad_op_width
        $error("fpu_byte_link: OP_WIDTH must be a multiple of 8");
    end
    if (RES_WIDTH % 8 != 0) begin : g_bad_res_width
        $error("fpu_byte_link: RES_WIDTH must be a multiple of 8");
    end

    link_state_e        state;
    logic [IN_CW-1:0]   in_cnt;
    logic [WAIT_CW-1:0] wait_cnt;
    logic               res_take;
    logic               ser_done;

    assign res_take = res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StLoad;
            in_ready    <= 1'b1;
            op_valid    <= 1'b0;
            res_ready   <= 1'b0;
            op_data     <= '0;
            in_cnt      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            frames_done <= '0;
        end else if (abort) begin
            state       <= StLoad;
            in_ready    <= 1'b1;
            op_valid    <= 1'b0;
            res_ready   <= 1'b0;
            op_data     <= '0;
            in_cnt      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                StLoad: begin
                    if (in_valid && in_ready) begin
                        op_data[{in_cnt, 3'b000} +: 8] <= in_byte;
                        if (in_cnt == IN_CW'(OP_BYTES - 1)) begin
                            in_cnt   <= '0;
                            in_ready <= 1'b0;
                            op_valid <= 1'b1;
                            state    <= StIssue;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (res_take) begin
                        res_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= StUnload;
                    end else if (wait_cnt == WAIT_CW'(TIMEOUT - 1)) begin
                        res_ready   <= 1'b0;
                        in_ready    <= 1'b1;
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= StLoad;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StUnload: begin
                    if (ser_done) begin
                        in_ready    <= 1'b1;
                        frames_done <= frames_done + 16'd1;
                        state       <= StLoad;
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

    fpu_link_ser #(
        .RES_WIDTH(RES_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (abort),
        .capture  (res_take),
        .res_data (res_data),
        .out_ready(out_ready),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_fpu_byte_link.sv
// Self-checking bench for fpu_byte_link: vector table plus hand-written corner sequences.
module tb_fpu_byte_link;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] op_data;
    logic         op_valid;
    logic         op_ready;
    logic [31:0]  res_data;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         timeout_err;
    logic [15:0]  frames_done;

    always #5 clk = ~clk;

    fpu_byte_link #(
        .NUM_OPS  (4),
        .OP_WIDTH (32),
        .RES_WIDTH(32),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_data    (op_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .timeout_err(timeout_err),
        .frames_done(frames_done)
    );

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        int           in_gap;
        int           op_delay;
        logic [127:0] exp_op;
        logic [31:0]  res;
        int           res_lat;
        int           stall_byte;
        int           stall_len;
    } vec_t;

    vec_t         vecs[3];
    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_frames = 0;
    logic [127:0] op_q[$];
    logic [7:0]   out_q[$];

    function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Scoreboard: handshakes pop the oldest expected item.
    always @(negedge clk) begin
        if (rst_n) begin
            if (op_valid && op_ready) begin
                if (op_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL op_unexpected: got %0h expected none", op_data);
                end else begin
                    check("op_data", op_data, op_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got %0h expected none", out_byte);
                end else begin
                    check("out_byte", {120'b0, out_byte}, {120'b0, out_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame and leaves the DUT in its first WAIT cycle.
    task automatic load_issue(input vec_t v);
        int ov;
        int t;
        op_ready = (v.op_delay == 0);
        op_q.push_back(v.exp_op);
        check("in_ready_load", in_ready, 1);
        for (int k = 0; k < 16; k++) begin
            if (v.in_gap != 0 && k % v.in_gap == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'h5A;
                tick();
            end
            in_valid = 1'b1;
            in_byte  = v.base + 8'(k) * v.step;
            tick();
        end
        in_valid = 1'b0;
        check("op_valid_next", op_valid, 1);
        for (int d = 0; d < v.op_delay; d++) begin
            tick();
            check("op_valid_hold", op_valid, 1);
        end
        op_ready = 1'b1;
        ov = 0;
        t  = 0;
        while (!res_ready && t < 20) begin
            if (op_valid) ov++;
            tick();
            t++;
        end
        check("wait_entry", res_ready, 1);
        check("op_valid_dropped", op_valid, 0);
        if (v.op_delay == 0) check("op_valid_one_cycle", ov, 1);
    endtask

    task automatic run_frame(input vec_t v);
        load_issue(v);
        for (int d = 0; d < v.res_lat; d++) tick();
        check("res_ready_hold", res_ready, 1);
        res_valid = 1'b1;
        res_data  = v.res;
        for (int b = 0; b < 4; b++) out_q.push_back(v.res[8*b +: 8]);
        tick();
        res_valid = 1'b0;
        res_data  = 32'h0;
        check("out_valid_next", out_valid, 1);
        check("out_byte_first", out_byte, v.res[7:0]);
        for (int b = 0; b < 4; b++) begin
            check("out_valid_run", out_valid, 1);
            if (b == v.stall_byte) begin
                out_ready = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    tick();
                    check("out_byte_stall", out_byte, v.res[8*b +: 8]);
                end
            end
            out_ready = 1'b1;
            tick();
        end
        exp_frames++;
        check("frames_done", frames_done, exp_frames);
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        vecs[0] = '{base: 8'h00, step: 8'h01, in_gap: 0, op_delay: 0,
                    exp_op: 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    res: 32'h40490FDB, res_lat: 0, stall_byte: -1, stall_len: 0};
        vecs[1] = '{base: 8'h10, step: 8'h03, in_gap: 5, op_delay: 2,
                    exp_op: 128'h3D3A3734_312E2B28_25221F1C_19161310,
                    res: 32'hDEADBEEF, res_lat: 3, stall_byte: -1, stall_len: 0};
        vecs[2] = '{base: 8'hF0, step: 8'h11, in_gap: 0, op_delay: 1,
                    exp_op: 128'hEFDECDBC_AB9A8978_67564534_231201F0,
                    res: 32'h40490FDB, res_lat: 1, stall_byte: 1, stall_len: 3};

        rst_n     = 1'b0;
        abort     = 1'b0;
        in_byte   = 8'h0;
        in_valid  = 1'b0;
        op_ready  = 1'b0;
        res_data  = 32'h0;
        res_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_op_valid", op_valid, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_op_data", op_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_frames_done", frames_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i]);
            check("no_timeout", timeout_err, 0);
        end

        // Core never answers: timeout after the 4th WAIT cycle.
        load_issue(vecs[0]);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("wait_res_ready", res_ready, 1);
            check("wait_no_timeout", timeout_err, 0);
        end
        tick();
        check("timeout_err_set", timeout_err, 1);
        check("timeout_res_ready", res_ready, 0);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_frames", frames_done, exp_frames);
        res_valid = 1'b1;
        res_data  = 32'hCAFEF00D;
        tick();
        res_valid = 1'b0;
        check("stray_res_ignored", out_valid, 0);
        check("stray_res_in_ready", in_ready, 1);
        run_frame(vecs[1]);
        check("timeout_sticky", timeout_err, 1);

        // Abort after 7 bytes discards the partial frame.
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_byte = 8'hA0 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_timeout_err", timeout_err, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_op_data", op_data, 0);
        check("abort_frames", frames_done, exp_frames);
        run_frame(vecs[2]);

        // Reset arriving mid-UNLOAD.
        load_issue(vecs[1]);
        res_valid = 1'b1;
        res_data  = 32'h11223344;
        for (int b = 0; b < 4; b++) out_q.push_back(res_data[8*b +: 8]);
        tick();
        res_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("pre_rst_out_byte", out_byte, 8'h33);
        #2;
        rst_n = 1'b0;
        #1;
        out_q.delete();
        exp_frames = 0;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_op_valid", op_valid, 0);
        check("arst_res_ready", res_ready, 0);
        check("arst_out_byte", out_byte, 0);
        check("arst_op_data", op_data, 0);
        check("arst_frames", frames_done, 0);
        tick();
        check("arst_hold_out_valid", out_valid, 0);
        check("arst_hold_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(vecs[0]);

        check("op_q_drained", op_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_byte_link.md
FPU_BYTE_LINK -- requirements
Module: fpu_byte_link

Interface
REQ-001 SHALL have parameter NUM_OPS, default 4, number of operands per frame (1..8).
REQ-002 SHALL have parameter OP_WIDTH, default 32, operand width in bits (multiple of 8).
REQ-003 SHALL have parameter RES_WIDTH, default 32, result width in bits (multiple of 8).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abandoning a frame (1..65535).
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port abort  in  1  synchronous frame flush.
REQ-008 SHALL have ports in_byte/in_valid/in_ready  in/in/out  8/1/1  byte-serial operand stream.
REQ-009 SHALL have ports op_data/op_valid/op_ready  out/out/in  NUM_OPS*OP_WIDTH/1/1  operand bundle to FP core.
REQ-010 SHALL have ports res_data/res_valid/res_ready  in/in/out  RES_WIDTH/1/1  result from FP core.
REQ-011 SHALL have ports out_byte/out_valid/out_ready  out/out/in  8/1/1  byte-serial result stream.
REQ-012 SHALL have ports timeout_err  out  1  sticky core-timeout flag; frames_done  out  16  completed-frame count.

Function
REQ-013 SHALL implement states LOAD, ISSUE, WAIT, UNLOAD; the only transitions are LOAD->ISSUE->WAIT->UNLOAD->LOAD and WAIT->LOAD on timeout.
REQ-014 SHALL register all outputs; in_ready=1 only in LOAD, op_valid=1 only in ISSUE, res_ready=1 only in WAIT, out_valid=1 only in UNLOAD.
REQ-015 SHALL accept one byte per cycle with in_valid&in_ready, little-endian: byte k goes to op_data[8k+7:8k], so operand 0 occupies op_data[OP_WIDTH-1:0] and is filled first.
REQ-016 SHALL leave LOAD on the edge that accepts byte NUM_OPS*OP_WIDTH/8-1, so op_valid=1 the next cycle; gaps in in_valid stall the counter without loss.
REQ-017 SHALL hold op_data and op_valid stable until op_valid&op_ready, then enter WAIT with a WAIT cycle counter at 0.
REQ-018 SHALL capture res_data on res_valid&res_ready and enter UNLOAD with out_byte=res_data[7:0] and out_valid=1 on the next cycle.
REQ-019 SHALL advance out_byte by one byte, LSB first, on each out_valid&out_ready, holding out_byte stable while out_ready=0.
REQ-020 SHALL return to LOAD and increment frames_done (wrapping 0xFFFF->0) on the handshake of the last result byte.
REQ-021 SHALL, when the WAIT counter reaches TIMEOUT without res_valid, set timeout_err, return to LOAD, and not increment frames_done; res_valid on that same cycle wins (capture, no timeout).
REQ-022 SHALL treat abort as top priority after reset: next state LOAD, byte counters and WAIT counter 0, timeout_err 0, and any partial operand or result discarded; frames_done is kept.
REQ-023 SHALL ignore in_valid outside LOAD and res_valid outside WAIT.

Reset
REQ-024 SHALL on rst_n=0 immediately force state LOAD, in_ready=1, op_valid=0, res_ready=0, out_valid=0, out_byte=0, op_data=0, timeout_err=0, frames_done=0, all counters 0.
REQ-025 SHALL resume normal operation on the first clk edge after rst_n deasserts, including when reset arrived mid-frame.

Structure
REQ-026 SHALL place the state enum, the byte-count constants (NUM_OPS*OP_WIDTH/8, RES_WIDTH/8) and the counter-width helper in the shared package fpu_link_pkg.
REQ-027 SHALL factor result capture and serialisation (REQ-018/019) into one sub-module, fpu_link_ser.
REQ-028 SHALL fail elaboration when OP_WIDTH or RES_WIDTH is not a multiple of 8.

Verification
REQ-029 SHALL cover this case with defaults: stream bytes 0x00..0x0F, op_ready=1 -> op_data=0x0F0E0D0C_0B0A0908_07060504_03020100 with op_valid high exactly one cycle.
REQ-030 SHALL cover this case: core returns 0x40490FDB, out_ready=1 -> out bytes DB,0F,49,40 on four consecutive cycles, then frames_done=1 and in_ready=1.
REQ-031 SHALL cover this case: out_ready held low 3 cycles on byte 1 -> out_byte stays 0x0F for those cycles with no byte skipped or repeated.
REQ-032 SHALL cover this case: TIMEOUT=4 and no res_valid -> timeout_err=1 after the 4th WAIT cycle, state LOAD, frames_done unchanged; a following frame completes normally.
REQ-033 SHALL cover this case: abort after 7 input bytes -> timeout_err=0 and the next 16 bytes form a fresh op_data with no residue.
REQ-034 SHALL cover this case: rst_n pulsed low during UNLOAD -> out_valid=0 immediately and all REQ-024 values held.
